tile_sprite_rom: RTL and testbench

Parametrised, pipelined tile-sprite source for the battleship board renderer. It holds line bitmaps for all board tile types and serves one requested pixel per cycle with fixed latency. It adds three features: horizontal mirroring, a frame-synchronous blink on HIT tiles, and a registered full-line output for debug/overlay.
It sits between the board-cell lookup and the RGB mux in the draw pipeline.

---
 rtl/tile_sprite_rom_pkg.sv | 25 ++
 rtl/tile_sprite_rom_blink_ctr.sv | 44 ++++
 rtl/tile_sprite_rom.sv | 147 ++++++++++++++
 tb/tb_tile_sprite_rom.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_sprite_rom_pkg.sv
// Shared tile-type encoding and default-geometry glyph data for the tile sprite ROM.
package tile_pkg;

  localparam int TILE_ID_W = 3;
  localparam int DEF_W     = 32;
  localparam int DEF_H     = 16;

  typedef enum logic [TILE_ID_W-1:0] {
    TILE_SHIP   = 3'd0,
    TILE_EMPTY  = 3'd1,
    TILE_HIT    = 3'd2,
    TILE_MISS   = 3'd3,
    TILE_SUNK   = 3'd4,
    TILE_CURSOR = 3'd5
  } tile_id_e;

  // 32x16 X glyph: row 0 is blank, rows 9..15 mirror rows 7..1 around row 8.
  localparam logic [31:0] HIT_X_32X16 [16] = '{
    32'h00000000, 32'h01C00380, 32'h00E00700, 32'h00700E00,
    32'h00381C00, 32'h001C3800, 32'h000E7000, 32'h0007E000,
    32'h0003C000, 32'h0007E000, 32'h000E7000, 32'h001C3800,
    32'h00381C00, 32'h00700E00, 32'h00E00700, 32'h01C00380
  };

endpackage

// File: rtl/tile_sprite_rom_blink_ctr.sv
// Frame-synchronous blink timer: toggles the blink phase every BLINK_FRAMES frame_start pulses.
module tile_blink_ctr
  import tile_pkg::*;
#(
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_start_i,
  output logic blink_phase_o
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             phase_q, phase_d;

  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    if (frame_start_i) begin
      if (count_q == LAST) begin
        count_d = '0;
        phase_d = ~phase_q;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      phase_q <= 1'b0;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  assign blink_phase_o = phase_q;

endmodule

// File: rtl/tile_sprite_rom.sv
// Two-stage pipelined tile bitmap source: one pixel per cycle plus the full mirrored line,
// with HIT tiles blanked during the active blink phase.
module tile_sprite_rom
  import tile_pkg::*;
#(
  parameter int TILE_W       = 32,
  parameter int TILE_H       = 16,
  parameter int TILE_TYPES   = 8,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame_start,
  input  logic                          req_valid,
  input  logic [$clog2(TILE_TYPES)-1:0] tile_id,
  input  logic [$clog2(TILE_H)-1:0]     row,
  input  logic [$clog2(TILE_W)-1:0]     col,
  input  logic                          mirror,
  input  logic                          blink_en,
  output logic                          pix_valid,
  output logic                          pix,
  output logic [TILE_W-1:0]             line_out,
  output logic                          blink_phase
);

  localparam int TID_W = $clog2(TILE_TYPES);
  localparam int ROW_W = $clog2(TILE_H);
  localparam int COL_W = $clog2(TILE_W);

  function automatic logic [TILE_W-1:0] hit_word(int r);
    logic [TILE_W-1:0] w;
    int k, c;
    w = '0;
    if (TILE_W == DEF_W && TILE_H == DEF_H) begin
      w = TILE_W'(HIT_X_32X16[4'(r)]);
    end else if (r != 0) begin
      // Other geometries get a 2-pixel-wide X scaled to the tile.
      k = (r <= TILE_H / 2) ? r : TILE_H - r;
      c = ((k - 1) * (TILE_W / 2 - 2)) / (TILE_H / 2 - 1);
      w[TILE_W-1-c] = 1'b1;
      w[TILE_W-2-c] = 1'b1;
      w[c]          = 1'b1;
      w[c+1]        = 1'b1;
    end
    return w;
  endfunction

  function automatic logic [TILE_W-1:0] tile_word(int id, int r);
    logic [TILE_W-1:0] w;
    w = '0;
    if (id == int'(TILE_SHIP)) begin
      w = '1;
    end else if (id == int'(TILE_HIT)) begin
      w = hit_word(r);
    end else if (id == int'(TILE_SUNK)) begin
      w = ~hit_word(r);
    end else if (id == int'(TILE_MISS)) begin
      for (int b = 0; b < TILE_W; b++) begin
        if (r == 1 || r == TILE_H - 2)
          w[b] = (b >= 1 && b <= TILE_W - 2);
        else if (r >= 2 && r <= TILE_H - 3)
          w[b] = (b >= 1 && b <= 3) || (b >= TILE_W - 4 && b <= TILE_W - 2);
      end
    end else if (id == int'(TILE_CURSOR)) begin
      if (r <= 1 || r >= TILE_H - 2) begin
        w = '1;
      end else begin
        w[TILE_W-1] = 1'b1;
        w[TILE_W-2] = 1'b1;
        w[1]        = 1'b1;
        w[0]        = 1'b1;
      end
    end
    return w;
  endfunction

  logic [TILE_W-1:0] rom [TILE_TYPES*TILE_H];

  for (genvar i = 0; i < TILE_TYPES * TILE_H; i++) begin : g_rom
    assign rom[i] = tile_word(i / TILE_H, i % TILE_H);
  end

  tile_blink_ctr #(
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_blink (
    .clk           (clk),
    .rst           (rst),
    .frame_start_i (frame_start),
    .blink_phase_o (blink_phase)
  );

  logic             s1_valid_q, s1_mirror_q;
  logic [TID_W-1:0] s1_id_q, eff_id_d;
  logic [ROW_W-1:0] s1_row_q;
  logic [COL_W-1:0] s1_col_q;

  always_comb begin
    eff_id_d = tile_id;
    if (blink_en && blink_phase && int'(tile_id) == int'(TILE_HIT))
      eff_id_d = TID_W'(TILE_EMPTY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_id_q     <= '0;
      s1_row_q    <= '0;
      s1_col_q    <= '0;
      s1_mirror_q <= 1'b0;
    end else begin
      s1_valid_q  <= req_valid;
      s1_id_q     <= eff_id_d;
      s1_row_q    <= row;
      s1_col_q    <= col;
      s1_mirror_q <= mirror;
    end
  end

  logic [TILE_W-1:0] word_d, line_d, line_q;
  logic              pix_d, pix_q, pix_valid_q;

  // Display column c always sits at line bit TILE_W-1-c, whether mirrored or not.
  always_comb begin
    word_d = rom[{s1_id_q, s1_row_q}];
    line_d = s1_mirror_q ? {<<{word_d}} : word_d;
    pix_d  = line_d[~s1_col_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_valid_q <= 1'b0;
      pix_q       <= 1'b0;
      line_q      <= '0;
    end else begin
      pix_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        pix_q  <= pix_d;
        line_q <= line_d;
      end
    end
  end

  assign pix_valid = pix_valid_q;
  assign pix       = pix_q;
  assign line_out  = line_q;

endmodule

// File: tb/tb_tile_sprite_rom.sv
// Directed and model-checked bench for tile_sprite_rom at 32x16, 8 tile types, 2-frame blink.
module tb_tile_sprite_rom;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_start = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  tile_id = '0;
  logic [3:0]  row = '0;
  logic [4:0]  col = '0;
  logic        mirror = 1'b0;
  logic        blink_en = 1'b0;
  logic        pix_valid, pix, blink_phase;
  logic [31:0] line_out;

  int checks = 0;
  int errors = 0;

  logic [31:0] hitRows [16] = '{
    32'h00000000, 32'h01C00380, 32'h00E00700, 32'h00700E00,
    32'h00381C00, 32'h001C3800, 32'h000E7000, 32'h0007E000,
    32'h0003C000, 32'h0007E000, 32'h000E7000, 32'h001C3800,
    32'h00381C00, 32'h00700E00, 32'h00E00700, 32'h01C00380
  };

  tile_sprite_rom #(
    .TILE_W(32), .TILE_H(16), .TILE_TYPES(8), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .req_valid(req_valid),
    .tile_id(tile_id), .row(row), .col(col), .mirror(mirror), .blink_en(blink_en),
    .pix_valid(pix_valid), .pix(pix), .line_out(line_out), .blink_phase(blink_phase)
  );

  always #5 clk = ~clk;

  // Pixel as seen from the left edge of the unmirrored tile (c = 0 is leftmost).
  function automatic logic expPix(int id, int r, int c);
    logic [31:0] h;
    h = hitRows[r];
    case (id)
      0: return 1'b1;
      2: return h[31-c];
      3: begin
        if (r == 1 || r == 14) return (c >= 1 && c <= 30);
        if (r >= 2 && r <= 13) return (c >= 1 && c <= 3) || (c >= 28 && c <= 30);
        return 1'b0;
      end
      4: return ~h[31-c];
      5: begin
        if (r <= 1 || r >= 14) return 1'b1;
        return (c <= 1 || c >= 30);
      end
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] expLine(int id, int r, int m);
    logic [31:0] l;
    for (int c = 0; c < 32; c++) l[31-c] = expPix(id, r, (m != 0) ? 31 - c : c);
    return l;
  endfunction

  task automatic set_req(input int id, input int r, input int c, input int m);
    req_valid = 1'b1;
    tile_id   = 3'(id);
    row       = 4'(r);
    col       = 5'(c);
    mirror    = (m != 0);
  endtask

  task automatic idle();
    req_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    frame_start = 1'b0;
    blink_en    = 1'b0;
    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_pix_valid got %b exp 0", pix_valid); end
    checks++; if (pix !== 1'b0) begin errors++; $display("[TB] FAIL rst_pix got %b exp 0", pix); end
    checks++; if (line_out !== 32'h0) begin errors++; $display("[TB] FAIL rst_line got %h exp 00000000", line_out); end
    checks++; if (blink_phase !== 1'b0) begin errors++; $display("[TB] FAIL rst_phase got %b exp 0", blink_phase); end
    set_req(0, 5, 0, 0);
    @(negedge clk);
    idle();
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("[TB] FAIL ship_latency1 got %b exp 0", pix_valid); end
    @(negedge clk);
    checks++; if (pix_valid !== 1'b1) begin errors++; $display("[TB] FAIL ship_valid got %b exp 1", pix_valid); end
    checks++; if (pix !== 1'b1) begin errors++; $display("[TB] FAIL ship_pix got %b exp 1", pix); end
    checks++; if (line_out !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL ship_line got %h exp FFFFFFFF", line_out); end
    @(negedge clk);
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("[TB] FAIL ship_valid_drop got %b exp 0", pix_valid); end
    checks++; if (line_out !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL line_hold got %h exp FFFFFFFF", line_out); end
    set_req(0, 3, 7, 0);
    repeat (2) @(negedge clk);
    checks++; if (pix_valid !== 1'b1) begin errors++; $display("[TB] FAIL stream_valid got %b exp 1", pix_valid); end
    #2 rst = 1'b1;
    idle();
    #1;
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("[TB] FAIL async_rst_valid got %b exp 0", pix_valid); end
    checks++; if (line_out !== 32'h0) begin errors++; $display("[TB] FAIL async_rst_line got %h exp 00000000", line_out); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (pix_valid !== 1'b0) begin errors++; $display("[TB] FAIL post_rst_valid%0d got %b exp 0", i, pix_valid); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_req(2, 8, 14, 0);
    @(negedge clk);
    set_req(2, 8, 16, 0);
    @(negedge clk);
    set_req(2, 8, 13, 0);
    checks++; if (pix !== 1'b1 || pix_valid !== 1'b1) begin errors++; $display("[TB] FAIL hit_c14 got pix=%b v=%b exp 1 1", pix, pix_valid); end
    checks++; if (line_out !== 32'h0003C000) begin errors++; $display("[TB] FAIL hit_r8_line got %h exp 0003C000", line_out); end
    @(negedge clk);
    set_req(0, 0, 0, 0);
    checks++; if (pix !== 1'b1 || pix_valid !== 1'b1) begin errors++; $display("[TB] FAIL hit_c16 got pix=%b v=%b exp 1 1", pix, pix_valid); end
    @(negedge clk);
    set_req(7, 9, 5, 0);
    checks++; if (pix !== 1'b0) begin errors++; $display("[TB] FAIL hit_c13 got %b exp 0", pix); end
    @(negedge clk);
    set_req(4, 8, 14, 0);
    checks++; if (pix !== 1'b1 || line_out !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL ship_r0 got pix=%b line=%h exp 1 FFFFFFFF", pix, line_out); end
    @(negedge clk);
    idle();
    checks++; if (pix !== 1'b0 || line_out !== 32'h0) begin errors++; $display("[TB] FAIL tile7 got pix=%b line=%h exp 0 00000000", pix, line_out); end
    @(negedge clk);
    checks++; if (pix !== 1'b0 || line_out !== 32'hFFFC3FFF) begin errors++; $display("[TB] FAIL sunk_r8 got pix=%b line=%h exp 0 FFFC3FFF", pix, line_out); end
  endtask

  task automatic test_mirror();
    logic expP [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    int   ids  [6] = '{3, 3, 3, 3, 5, 5};
    int   rows [6] = '{1, 1, 1, 1, 0, 0};
    int   cols [6] = '{0, 1, 0, 1, 31, 0};
    int   mirs [6] = '{0, 0, 1, 1, 0, 0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i < 6) set_req(ids[i], rows[i], cols[i], mirs[i]);
      else idle();
      if (i >= 2) begin
        checks++;
        if (pix !== expP[i-2] || pix_valid !== 1'b1) begin
          errors++; $display("[TB] FAIL mirror_vec%0d got pix=%b v=%b exp %b 1", i - 2, pix, pix_valid, expP[i-2]);
        end
        if (i - 2 == 3) begin
          checks++; if (line_out !== 32'h7FFFFFFE) begin errors++; $display("[TB] FAIL miss_r1_mirror_line got %h exp 7FFFFFFE", line_out); end
        end
      end
      @(negedge clk);
    end
    set_req(5, 5, 2, 0);
    @(negedge clk);
    set_req(5, 5, 1, 1);
    @(negedge clk);
    idle();
    checks++; if (pix !== 1'b0 || line_out !== 32'hC0000003) begin errors++; $display("[TB] FAIL cursor_r5 got pix=%b line=%h exp 0 C0000003", pix, line_out); end
    @(negedge clk);
    checks++; if (pix !== 1'b1) begin errors++; $display("[TB] FAIL cursor_r5_mirror got %b exp 1", pix); end
  endtask

  task automatic hit_probe(input string name, input logic expP, input logic [31:0] expL);
    set_req(2, 8, 14, 0);
    @(negedge clk);
    idle();
    @(negedge clk);
    checks++;
    if (pix !== expP || line_out !== expL) begin
      errors++; $display("[TB] FAIL %s got pix=%b line=%h exp %b %h", name, pix, line_out, expP, expL);
    end
  endtask

  task automatic test_blink();
    do_reset();
    pulse_frame();
    checks++; if (blink_phase !== 1'b0) begin errors++; $display("[TB] FAIL phase_after1 got %b exp 0", blink_phase); end
    pulse_frame();
    checks++; if (blink_phase !== 1'b1) begin errors++; $display("[TB] FAIL phase_after2 got %b exp 1", blink_phase); end
    blink_en = 1'b1;
    hit_probe("blink_off", 1'b0, 32'h0);
    blink_en = 1'b0;
    hit_probe("blink_disabled", 1'b1, 32'h0003C000);
    pulse_frame();
    pulse_frame();
    checks++; if (blink_phase !== 1'b0) begin errors++; $display("[TB] FAIL phase_after4 got %b exp 0", blink_phase); end
    blink_en = 1'b1;
    hit_probe("blink_restored", 1'b1, 32'h0003C000);
  endtask

  task automatic test_coincident();
    do_reset();
    pulse_frame();
    blink_en    = 1'b1;
    frame_start = 1'b1;
    set_req(2, 8, 14, 0);
    @(negedge clk);
    frame_start = 1'b0;
    set_req(2, 8, 14, 0);
    @(negedge clk);
    idle();
    checks++; if (pix !== 1'b1 || line_out !== 32'h0003C000) begin errors++; $display("[TB] FAIL coinc_old_phase got pix=%b line=%h exp 1 0003C000", pix, line_out); end
    checks++; if (blink_phase !== 1'b1) begin errors++; $display("[TB] FAIL coinc_phase got %b exp 1", blink_phase); end
    @(negedge clk);
    checks++; if (pix !== 1'b0 || line_out !== 32'h0) begin errors++; $display("[TB] FAIL coinc_new_phase got pix=%b line=%h exp 0 00000000", pix, line_out); end
    blink_en = 1'b0;
  endtask

  task automatic test_random();
    logic        v1 = 1'b0, v2 = 1'b0;
    logic        p1 = 1'b0, p2 = 1'b0;
    logic [31:0] l1 = '0, l2 = '0;
    int          reqCount = 0, validCount = 0, localErr = 0;
    int          id, r, c, m, eid;
    do_reset();
    pulse_frame();
    pulse_frame();
    for (int i = 0; i < 1002; i++) begin
      if (pix_valid === 1'b1) validCount++;
      if (pix_valid !== v2 || (v2 && (pix !== p2 || line_out !== l2))) begin
        localErr++;
        if (localErr <= 5)
          $display("[TB] FAIL rand_step%0d got v=%b pix=%b line=%h exp %b %b %h", i, pix_valid, pix, line_out, v2, p2, l2);
      end
      v2 = v1; p2 = p1; l2 = l1;
      if (i < 1000 && $urandom_range(3) != 0) begin
        id = $urandom_range(7); r = $urandom_range(15); c = $urandom_range(31); m = $urandom_range(1);
        blink_en = 1'($urandom_range(1));
        eid = (id == 2 && blink_en) ? 1 : id;
        set_req(id, r, c, m);
        reqCount++;
        v1 = 1'b1;
        l1 = expLine(eid, r, m);
        p1 = expPix(eid, r, (m != 0) ? 31 - c : c);
      end else begin
        idle();
        v1 = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (localErr != 0) begin errors++; $display("[TB] FAIL rand_stream got %0d bad steps exp 0", localErr); end
    checks++;
    if (validCount != reqCount) begin errors++; $display("[TB] FAIL rand_count got %0d valid exp %0d", validCount, reqCount); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_mirror();
    test_blink();
    test_coincident();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
